// File: rtl/fetch_decode_if.sv
// fetch_decode_if: PC, flag and program-load inputs plus decode strobes of the fetch/decode unit
interface fetch_decode_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  pc;
  logic               zero_flag;
  logic               carry_flag;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               pc_inc;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_target;
  logic [INSTR_W-1:0] ir_out;
  logic [3:0]         operand;
  logic               ld_a;
  logic               alu_add;
  logic               alu_sub;
  logic               out_en;
  logic               halt;
  logic [1:0]         state_out;
  modport master (
    output pc, zero_flag, carry_flag, prog_we, prog_addr, prog_data,
    input  pc_inc, pc_load, pc_target, ir_out, operand, ld_a, alu_add, alu_sub, out_en, halt, state_out
  );
  modport slave (
    input  pc, zero_flag, carry_flag, prog_we, prog_addr, prog_data,
    output pc_inc, pc_load, pc_target, ir_out, operand, ld_a, alu_add, alu_sub, out_en, halt, state_out
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: 3-cycle fetch/decode/execute controller driving the PC and execute strobes
module fetch_decode_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input logic           clk,
  input logic           rst,
  fetch_decode_if.slave bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] mem [2**ADDR_W];
  logic [3:0]         op;
  logic               ex;
  logic               taken;
  // program memory is never reset so it can be loaded while the core is held in reset
  always_ff @(posedge clk)
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  // sequencer: FETCH captures mem[pc] (old data on a same-edge write), EXEC ends in HALT on opcode F
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      ir    <= state == FETCH ? mem[bus.pc] : ir;
      state <= state == FETCH ? DECODE :
               state == DECODE ? EXEC :
               state == EXEC && op != 4'hF ? FETCH : HALT;
    end
  // Moore decode of state and ir; flags only matter during EXEC
  always_comb begin
    op            = ir[INSTR_W-1:INSTR_W-4];
    ex            = state == EXEC;
    taken         = ex && (op == 4'h5 || (op == 4'h6 && bus.zero_flag) || (op == 4'h7 && bus.carry_flag));
    bus.pc_load   = taken;
    bus.pc_target = taken ? ir[ADDR_W-1:0] : '0;
    bus.pc_inc    = ex && !taken && op != 4'hF;
    bus.ld_a      = ex && op == 4'h1;
    bus.alu_add   = ex && op == 4'h2;
    bus.alu_sub   = ex && op == 4'h3;
    bus.out_en    = ex && op == 4'h4;
    bus.halt      = state == HALT;
    bus.state_out = state;
    bus.ir_out    = ir;
    bus.operand   = ir[3:0];
  end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: randomized self-checking bench against an instruction-level reference model
module tb_fetch_decode_unit;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  logic [7:0] m [16];
  logic [3:0] pc = 0;
  fetch_decode_if bus ();
  fetch_decode_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {bus.pc_inc, bus.pc_load, bus.pc_target, bus.ld_a, bus.alu_add, bus.alu_sub, bus.out_en, bus.halt};
  endfunction

  // expected EXEC outputs {inc, load, target[3:0], ld_a, add, sub, out, halt} from the ISA rules
  function automatic logic [10:0] model(input logic [7:0] i, input logic zf, input logic cf);
    logic [3:0] op;
    logic tk;
    op = i[7:4];
    tk = op == 4'h5 || (op == 4'h6 && zf) || (op == 4'h7 && cf);
    return {op != 4'hF && !tk, tk, tk ? i[3:0] : 4'h0, op == 4'h1, op == 4'h2, op == 4'h3, op == 4'h4, 1'b0};
  endfunction

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    rst = 1;
    bus.prog_we = 1;
    bus.prog_addr = a;
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we = 0;
    m[a] = d;
    rst = 0;
  endtask

  task automatic run_instr(input logic zf, input logic cf, input logic we = 0,
                           input logic [3:0] wa = 0, input logic [7:0] wd = 0);
    logic [7:0] ei;
    logic [10:0] e;
    bus.pc = pc;
    bus.zero_flag = 1'($urandom);
    bus.carry_flag = 1'($urandom);
    bus.prog_we = we;
    bus.prog_addr = wa;
    bus.prog_data = wd;
    ei = m[pc];
    #1 checks++;
    if (bus.state_out !== 2'd0 || obs() !== 11'd0) begin
      errors++;
      $display("FAIL fetch_quiet pc=%h: state=%0d strobes=%h want state=0 strobes=000", pc, bus.state_out, obs());
    end
    @(negedge clk);
    bus.prog_we = 0;
    if (we) m[wa] = wd;
    bus.zero_flag = 1'($urandom);
    bus.carry_flag = 1'($urandom);
    #1 checks++;
    if ({bus.state_out, bus.ir_out, bus.operand, obs()} !== {2'd1, ei, ei[3:0], 11'd0}) begin
      errors++;
      $display("FAIL decode pc=%h: state=%0d ir=%h opnd=%h strobes=%h want state=1 ir=%h opnd=%h strobes=000",
               pc, bus.state_out, bus.ir_out, bus.operand, obs(), ei, ei[3:0]);
    end
    @(negedge clk);
    bus.zero_flag = zf;
    bus.carry_flag = cf;
    e = model(ei, zf, cf);
    #1 checks++;
    if (bus.state_out !== 2'd2 || obs() !== e) begin
      errors++;
      $display("FAIL exec pc=%h ir=%h z=%b c=%b: state=%0d strobes=%h want state=2 strobes=%h",
               pc, ei, zf, cf, bus.state_out, obs(), e);
    end
    pc = ei[7:4] == 4'hF ? pc : e[9] ? e[8:5] : pc + 4'd1;
    @(negedge clk);
    checks++;
    if (bus.state_out !== (ei[7:4] == 4'hF ? 2'd3 : 2'd0)) begin
      errors++;
      $display("FAIL next_state ir=%h: state=%0d want %0d", ei, bus.state_out, ei[7:4] == 4'hF ? 3 : 0);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (bus.state_out !== 2'd0 || bus.ir_out !== 8'h00 || obs() !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d ir=%h strobes=%h want 0/00/000", bus.state_out, bus.ir_out, obs());
    end
    load(4'h0, 8'h13);
    pc = 0;
    bus.pc = 0;
    @(negedge clk);
    @(negedge clk);
    #1 checks++;
    if (bus.ld_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_exec: ld_a=%b want 1", bus.ld_a);
    end
    rst = 1;
    #1 checks++;
    if (bus.state_out !== 2'd0 || bus.ir_out !== 8'h00 || obs() !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d ir=%h strobes=%h want 0/00/000", bus.state_out, bus.ir_out, obs());
    end
    @(negedge clk);
    rst = 0;
    run_instr(1'b0, 1'b0);
  endtask

  task automatic test_program;
    load(4'h0, 8'h13);
    load(4'h1, 8'h27);
    load(4'h2, {4'h4, 4'($urandom)});
    pc = 0;
    repeat (3) run_instr(1'($urandom), 1'($urandom));
    checks++;
    if (pc !== 4'h3) begin
      errors++;
      $display("FAIL program_pc: pc=%h want 3", pc);
    end
  endtask

  task automatic test_jmp;
    load(4'h5, 8'h5A);
    load(4'hA, {4'h1, 4'($urandom)});
    pc = 5;
    run_instr(1'($urandom), 1'($urandom));
    checks++;
    if (pc !== 4'hA) begin
      errors++;
      $display("FAIL jmp_target: pc=%h want a", pc);
    end
    run_instr(1'($urandom), 1'($urandom));
  endtask

  task automatic test_cond;
    load(4'h0, 8'h63);
    pc = 0; run_instr(1'b0, 1'b1);
    pc = 0; run_instr(1'b1, 1'b0);
    load(4'h0, 8'h7C);
    pc = 0; run_instr(1'b1, 1'b0);
    pc = 0; run_instr(1'b0, 1'b1);
  endtask

  task automatic test_halt;
    load(4'h3, 8'hF0);
    pc = 3;
    run_instr(1'($urandom), 1'($urandom));
    repeat (22) begin
      bus.zero_flag = 1'($urandom);
      bus.carry_flag = 1'($urandom);
      #1 checks++;
      if (bus.state_out !== 2'd3 || obs() !== 11'd1) begin
        errors++;
        $display("FAIL halt_hold: state=%0d strobes=%h want state=3 strobes=001", bus.state_out, obs());
      end
      @(negedge clk);
    end
    rst = 1;
    #1 checks++;
    if (bus.state_out !== 2'd0 || bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d halt=%b want 0/0", bus.state_out, bus.halt);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_write_same;
    load(4'h6, 8'h95);
    pc = 6;
    run_instr(1'($urandom), 1'($urandom), 1'b1, 4'h6, 8'h21);
    pc = 6;
    run_instr(1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) load(4'(i), {4'($urandom_range(0, 14)), 4'($urandom)});
    pc = 4'($urandom);
    repeat (40) run_instr(1'($urandom), 1'($urandom));
  endtask

  initial begin
    bus.pc = 0;
    bus.zero_flag = 0;
    bus.carry_flag = 0;
    bus.prog_we = 0;
    bus.prog_addr = 0;
    bus.prog_data = 0;
    test_reset;
    test_program;
    test_jmp;
    test_cond;
    test_halt;
    test_write_same;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Instruction fetch/decode controller sitting directly downstream of the 4-bit program counter.
- Consumes the PC value, fetches an 8-bit instruction from an internal 16-entry program memory, decodes it and drives the execute strobes.
- Drives the PC's advance/load controls: increment, or load a jump target (the PC's A input with ctrl=1).
- Fixed 3-cycle instruction sequence: FETCH, DECODE, EXEC.

Parameters:
ADDR_W, 4, PC/program-memory address width (memory depth = 2**ADDR_W)
INSTR_W, 8, instruction width: [7:4] opcode, [3:0] operand

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
pc  input  ADDR_W  current program counter value
zero_flag  input  1  ALU zero flag, sampled in EXEC
carry_flag  input  1  ALU carry flag, sampled in EXEC
prog_we  input  1  program-memory write enable
prog_addr  input  ADDR_W  program-memory write address
prog_data  input  INSTR_W  program-memory write data
pc_inc  output  1  PC advance strobe
pc_load  output  1  PC load strobe (to PC ctrl)
pc_target  output  ADDR_W  jump target (to PC A)
ir_out  output  INSTR_W  instruction register contents
operand  output  4  ir[3:0]
ld_a  output  1  load accumulator strobe
alu_add  output  1  add strobe
alu_sub  output  1  subtract strobe
out_en  output  1  output-register strobe
halt  output  1  processor halted
state_out  output  2  FSM state: 0 FETCH, 1 DECODE, 2 EXEC, 3 HALT

Behaviour:
- Reset (async, immediate):
  - state=FETCH, ir=0.
  - All strobes, halt and pc_target are 0.
  - Program memory is NOT cleared.
- Program memory:
  - Synchronous write on clk when prog_we=1, in any state, including while rst=1.
  - A write and a FETCH to the same address on the same edge: the FETCH captures the old contents.
- FSM transitions:
  - FETCH: ir <= mem[pc] on the edge; go to DECODE.
  - DECODE: go to EXEC. No strobes asserted.
  - EXEC: go to FETCH, except opcode F, which goes to HALT.
  - HALT: stays in HALT until reset. halt=1. All other strobes are 0.
- Opcodes:
  - 0 NOP
  - 1 LDA (ld_a)
  - 2 ADD (alu_add)
  - 3 SUB (alu_sub)
  - 4 OUT (out_en)
  - 5 JMP (unconditional)
  - 6 JZ (jump if zero_flag)
  - 7 JC (jump if carry_flag)
  - F HLT
  - 8–E are NOP.
- Outputs are a Moore decode of (state, ir) and are asserted only while state=EXEC, for exactly one cycle per instruction:
  - Execute strobes: at most one of ld_a/alu_add/alu_sub/out_en is high, per the opcode.
  - Jump taken: pc_load=1, pc_target=operand, pc_inc=0.
  - Jump not taken, and every other non-HLT opcode: pc_inc=1, pc_load=0.
  - HLT in EXEC: pc_inc=0, pc_load=0. The PC holds.
  - pc_target is 0 whenever pc_load=0.
- Flags are sampled combinationally during the EXEC cycle only.
- PC timing:
  - The PC updates on the edge that ends EXEC.
  - The next FETCH reads the updated pc. pc must be stable from the start of FETCH.
- Throughput: one instruction per 3 cycles. Fetch-to-first-strobe latency is 2 cycles.
- operand and ir_out always reflect ir, independent of state.
- pc wrap (F→0) is the PC's responsibility. This block treats address 0 like any other address.
- Reset mid-instruction: strobes drop immediately. After rst deasserts, the first rising edge performs FETCH.

Test Plan:
- Reset, then rst high mid-EXEC: state_out=0, all strobes and halt=0 with no clock edge; memory contents unchanged.
- Load mem[0]=0x13, mem[1]=0x27, mem[2]=0x4x; step the PC by pc_inc:
  - ld_a in cycle 3 with operand=3.
  - alu_add in cycle 6 with operand=7.
  - out_en in cycle 9.
  - pc_inc=1 in each EXEC; exactly one strobe per instruction.
- mem[5]=0x5A at pc=5: EXEC gives pc_load=1, pc_target=0xA, pc_inc=0; the next FETCH with pc=0xA loads mem[0xA].
- JZ 0x63 with zero_flag=0, then with zero_flag=1:
  - flag 0: pc_inc=1, pc_load=0.
  - flag 1: pc_load=1, pc_target=3.
  - Repeat with 0x7C and carry_flag for JC.
- mem[pc]=0xF0: after EXEC, state_out=3 and halt=1 persist for 20+ cycles with no strobes; rst returns to FETCH.
- prog_we writing 0x21 to addr=pc on the FETCH edge: ir gets the old value. The next fetch of that address returns 0x21. Opcode 0x9 gives pc_inc only.
